// File: rtl/call_ret_pkg.sv
// Shared types and defaults for the call/return sequencer and its depth tracker.
package call_ret_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUSH  = 2'd1,
        POP   = 2'd2,
        FAULT = 2'd3
    } state_e;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned DEPTH_W(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/call_return_ctrl_if.sv
// Stack-side bus between the call/return sequencer (master) and the return-address stack (slave).
interface call_return_ctrl_if #(
    parameter int unsigned ADDR_W = call_ret_pkg::ADDR_W_DEF
);
    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_data_in;
    logic [ADDR_W-1:0] stk_data_out;

    modport master (
        output stk_push,
        output stk_pop,
        output stk_data_in,
        input  stk_data_out
    );

    modport slave (
        input  stk_push,
        input  stk_pop,
        input  stk_data_in,
        output stk_data_out
    );
endinterface

// File: rtl/call_return_ctrl_depth_tracker.sv
// Saturating up/down counter tracking live return-stack entries (0..DEPTH).
module depth_tracker
    import call_ret_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc,
    input  logic                      dec,
    output logic [DEPTH_W(DEPTH)-1:0] depth,
    output logic                      is_full,
    output logic                      is_empty
);

    localparam int unsigned DW = DEPTH_W(DEPTH);

    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;

    always_comb begin
        depth_d = depth_q;
        if (inc && !dec && (depth_q != DW'(DEPTH))) begin
            depth_d = depth_q + DW'(1);
        end else if (dec && !inc && (depth_q != '0)) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign depth    = depth_q;
    assign is_full  = (depth_q == DW'(DEPTH));
    assign is_empty = (depth_q == '0);

endmodule

// File: rtl/call_return_ctrl.sv
// Call/return sequencer driving the return-address stack and the fetch redirect.
// Optional feature: CALL_RET_OVF_TRAP_EN traps over/underflow into a sticky FAULT state.
module call_return_ctrl
    import call_ret_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      call,
    input  logic                      ret,
    input  logic [ADDR_W-1:0]         pc,
    input  logic [ADDR_W-1:0]         target,
    call_return_ctrl_if.master        stk,
    output logic                      redirect,
    output logic [ADDR_W-1:0]         redirect_pc,
    output logic                      busy,
    output logic [DEPTH_W(DEPTH)-1:0] depth,
    output logic                      fault
);

`ifdef CALL_RET_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic              stk_push_q, stk_push_d;
    logic              stk_pop_q, stk_pop_d;
    logic [ADDR_W-1:0] stk_data_in_q, stk_data_in_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic              inc_c, dec_c;
    logic              is_full, is_empty;

    // Next state, stack-side latches and counter strobes; outputs follow state_d so they register with it.
    always_comb begin
        state_d       = state_q;
        stk_data_in_d = stk_data_in_q;
        redirect_pc_d = redirect_pc_q;
        inc_c         = 1'b0;
        dec_c         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (call) begin
                    if (TRAP_EN && is_full) begin
                        state_d = FAULT;
                    end else begin
                        state_d       = PUSH;
                        inc_c         = 1'b1;
                        stk_data_in_d = ADDR_W'(pc + ADDR_W'(1));
                        redirect_pc_d = target;
                    end
                end else if (ret) begin
                    if (TRAP_EN && is_empty) begin
                        state_d = FAULT;
                    end else begin
                        state_d       = POP;
                        dec_c         = 1'b1;
                        redirect_pc_d = stk.stk_data_out;
                    end
                end
            end
            PUSH:    state_d = IDLE;
            POP:     state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        stk_push_d = (state_d == PUSH);
        stk_pop_d  = (state_d == POP);
        redirect_d = (state_d == PUSH) || (state_d == POP);
        busy_d     = (state_d != IDLE);
        fault_d    = TRAP_EN && (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            stk_push_q    <= 1'b0;
            stk_pop_q     <= 1'b0;
            stk_data_in_q <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            stk_push_q    <= stk_push_d;
            stk_pop_q     <= stk_pop_d;
            stk_data_in_q <= stk_data_in_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
        end
    end

    depth_tracker #(
        .DEPTH (DEPTH)
    ) u_depth_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc_c),
        .dec      (dec_c),
        .depth    (depth),
        .is_full  (is_full),
        .is_empty (is_empty)
    );

    assign stk.stk_push    = stk_push_q;
    assign stk.stk_pop     = stk_pop_q;
    assign stk.stk_data_in = stk_data_in_q;
    assign redirect        = redirect_q;
    assign redirect_pc     = redirect_pc_q;
    assign busy            = busy_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Randomized bench for call_return_ctrl against a cycle-level behavioural model and an 8-entry wrapping stack.
module tb_call_return_ctrl;

`ifdef CALL_RET_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        call, ret;
    logic [11:0] pc, target;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        busy;
    logic [3:0]  depth;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    call_return_ctrl_if #(.ADDR_W(12)) stk_if ();

    call_return_ctrl #(.ADDR_W(12), .DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .target      (target),
        .stk         (stk_if),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy),
        .depth       (depth),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Environment stack: no reset, wraps around, shows top entry combinationally.
    logic [11:0] mem [0:7] = '{default: 12'h000};
    logic [2:0]  sp = 3'd0;
    assign stk_if.stk_data_out = mem[sp - 3'd1];

    always @(posedge clk) begin
        if (stk_if.stk_push === 1'b1) begin
            mem[sp] <= stk_if.stk_data_in;
            sp      <= sp + 3'd1;
        end else if (stk_if.stk_pop === 1'b1) begin
            sp <= sp - 3'd1;
        end
    end

    // Reference model: phase 0 = accepting, 1 = serving a request, 2 = trapped.
    int          m_phase = 0;
    int          m_depth = 0;
    logic        m_push = 0, m_pop = 0, m_redir = 0, m_busy = 0, m_fault = 0;
    logic [11:0] m_din = 0, m_rpc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic c, input logic r, input logic [11:0] p,
                              input logic [11:0] t, input logic rn, input logic [11:0] top);
        m_push  = 0;
        m_pop   = 0;
        m_redir = 0;
        if (!rn) begin
            m_phase = 0; m_depth = 0; m_busy = 0; m_fault = 0; m_din = 0; m_rpc = 0;
        end else if (m_phase == 2) begin
            m_busy = 1; m_fault = 1;
        end else if (m_phase == 1) begin
            m_phase = 0; m_busy = 0;
        end else begin
            m_busy = 0;
            if (c) begin
                if (TRAP && m_depth == 8) begin
                    m_phase = 2; m_busy = 1; m_fault = 1;
                end else begin
                    m_phase = 1; m_push = 1; m_redir = 1; m_busy = 1;
                    m_din   = 12'((int'(p) + 1) % 4096);
                    m_rpc   = t;
                    if (m_depth < 8) m_depth++;
                end
            end else if (r) begin
                if (TRAP && m_depth == 0) begin
                    m_phase = 2; m_busy = 1; m_fault = 1;
                end else begin
                    m_phase = 1; m_pop = 1; m_redir = 1; m_busy = 1;
                    m_rpc   = top;
                    if (m_depth > 0) m_depth--;
                end
            end
        end
    endtask

    task automatic step(input logic c, input logic r, input logic [11:0] p,
                        input logic [11:0] t, input logic rn);
        call = c; ret = r; pc = p; target = t; rst_n = rn;
        model_step(c, r, p, t, rn, stk_if.stk_data_out);
        @(posedge clk);
        #1;
        check_eq("stk_push",    32'(stk_if.stk_push),    32'(m_push));
        check_eq("stk_pop",     32'(stk_if.stk_pop),     32'(m_pop));
        check_eq("stk_data_in", 32'(stk_if.stk_data_in), 32'(m_din));
        check_eq("redirect",    32'(redirect),           32'(m_redir));
        check_eq("redirect_pc", 32'(redirect_pc),        32'(m_rpc));
        check_eq("busy",        32'(busy),               32'(m_busy));
        check_eq("depth",       32'(depth),              32'(m_depth));
        check_eq("fault",       32'(fault),              32'(m_fault));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 12'h000, 12'h000, 1'b1);
    endtask

    task automatic reset();
        step(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    endtask

    initial begin
        call = 0; ret = 0; pc = 0; target = 0; rst_n = 0;
        reset();
        reset();

        // Basic call then return of the pushed address.
        step(1'b1, 1'b0, 12'h010, 12'h200, 1'b1);
        check_eq("first_push_din", 32'(stk_if.stk_data_in), 32'h011);
        idle();
        step(1'b0, 1'b1, 12'h000, 12'h000, 1'b1);
        check_eq("ret_rpc", 32'(redirect_pc), 32'h011);
        idle();

        // PC wrap, then simultaneous call/ret.
        step(1'b1, 1'b0, 12'hFFF, 12'h123, 1'b1);
        idle();
        step(1'b1, 1'b1, 12'h040, 12'h300, 1'b1);
        idle();
        idle();

        // Fill to DEPTH, then one more call, then a ret while possibly trapped.
        reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 12'(12'h100 + i), 12'(12'h800 + i), 1'b1);
            idle();
        end
        check_eq("full_depth", 32'(depth), 32'd8);
        step(1'b0, 1'b1, 12'h000, 12'h000, 1'b1);
        idle();
        reset();
        idle();

        // Ret at depth 0.
        step(1'b0, 1'b1, 12'h000, 12'h000, 1'b1);
        idle();
        reset();

        // Reset landing in the POP cycle.
        step(1'b1, 1'b0, 12'h055, 12'h0AA, 1'b1);
        idle();
        step(1'b0, 1'b1, 12'h000, 12'h000, 1'b1);
        reset();
        idle();

        // Requests arriving while busy are dropped.
        step(1'b1, 1'b0, 12'h333, 12'h444, 1'b1);
        step(1'b1, 1'b0, 12'h555, 12'h666, 1'b1);
        step(1'b0, 1'b1, 12'h000, 12'h000, 1'b1);
        idle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic        c, r, rn;
            logic [11:0] p, t;
            c  = ($urandom_range(0, 99) < 40);
            r  = ($urandom_range(0, 99) < 35);
            rn = ($urandom_range(0, 99) >= 2);
            p  = 12'($urandom);
            t  = 12'($urandom);
            step(c, r, p, t, rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
